// File: rtl/monitor_pio_arb_if.sv
// Requester-side and PIO-slave-side signals of the shared PIO read arbiter.
// master: requesters plus the PIO slave; slave: the arbiter itself.
interface monitor_pio_arb_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   rvalid;
  logic [DATA_W-1:0]  rdata;
  logic               busy;
  logic [1:0]         s_address;
  logic [DATA_W-1:0]  s_readdata;

  modport master (
    output req, req_addr, s_readdata,
    input  grant, rvalid, rdata, busy, s_address
  );

  modport slave (
    input  req, req_addr, s_readdata,
    output grant, rvalid, rdata, busy, s_address
  );
endinterface

// File: rtl/monitor_pio_arb.sv
// Round-robin arbiter sharing one registered PIO read slave among N_REQ requesters.
// Each transaction runs IDLE -> WAIT -> CAPTURE, with a fixed read latency.
module monitor_pio_arb #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              reset_n,
  monitor_pio_arb_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StWait, StCapture} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic               arb_go;
  logic [N_REQ-1:0]   win_onehot;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   rvalid_q;
  logic [1:0]         s_address_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               busy;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_grant_q) + k) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // The rvalid cycle is a dead IDLE cycle: the served requester is still
  // holding req while it sees its pulse, so arbitrating here would serve it twice.
  assign arb_go = (state_q == StIdle) && (rvalid_q == '0) && win_found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arb_go) state_d = StWait;
      StWait:    state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      s_address_q  <= '0;
      win_q        <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
    end else begin
      rvalid_q <= '0;
      if (arb_go) begin
        grant_q     <= win_onehot;
        win_q       <= win_idx;
        s_address_q <= bus.req_addr[{win_idx, 1'b0} +: 2];
      end
      if (state_q == StCapture) begin
        rdata_q      <= bus.s_readdata;
        rvalid_q     <= grant_q;
        last_grant_q <= win_q;
        grant_q      <= '0;
        s_address_q  <= '0;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy;
  assign bus.s_address = s_address_q;

endmodule

// File: tb/tb_monitor_pio_arb.sv
// Randomized and directed bench for monitor_pio_arb against a timeline-based
// reference model of the round-robin PIO read arbiter.
module tb_monitor_pio_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  monitor_pio_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  monitor_pio_arb #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a transaction granted at edge E completes at edge E+2,
  // and the next arbitration may happen no earlier than edge E+4.
  bit          m_active;
  int          m_edge, m_win, m_last, m_next;
  logic [1:0]  m_addr;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  m_rvalid;
  logic [N-1:0]  prev_grant;
  logic [DW-1:0] regs [4];
  logic [N-1:0]  hold;
  int          order[$];
  int          when[$];
  int          side_hits;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] rq);
    for (int k = 1; k <= int'(N); k++) begin
      if (rq[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_last     = N - 1;
    m_rdata    = '0;
    m_rvalid   = '0;
    m_next     = 0;
    prev_grant = '0;
  endtask

  task automatic step();
    logic [N-1:0]   rq;
    logic [2*N-1:0] ra;
    logic [1:0]     sa;
    logic [N-1:0]   exp_grant;
    int             w;
    rq = bus.req;
    ra = bus.req_addr;
    sa = bus.s_address;
    @(posedge clk);
    #1;
    bus.s_readdata = regs[sa];
    cyc++;
    m_rvalid = '0;
    if (m_active && cyc == m_edge + 2) begin
      m_rdata          = regs[m_addr];
      m_rvalid[m_win]  = 1'b1;
      m_last           = m_win;
      m_active         = 1'b0;
      m_next           = cyc + 2;
    end else if (!m_active && cyc >= m_next) begin
      w = rr_pick(m_last, rq);
      if (w >= 0) begin
        m_active = 1'b1;
        m_win    = w;
        m_edge   = cyc;
        m_addr   = ra[2*w +: 2];
      end
    end
    exp_grant = '0;
    if (m_active) exp_grant[m_win] = 1'b1;
    check_val("grant", bus.grant, exp_grant);
    check_val("s_address", bus.s_address, m_active ? m_addr : 2'd0);
    check_val("rvalid", bus.rvalid, m_rvalid);
    check_val("rdata", bus.rdata, m_rdata);
    check_val("busy", bus.busy, m_active);
    check_val("grant_onehot0", $onehot0(bus.grant), 1);
    check_val("rvalid_subset", bus.rvalid & ~prev_grant, 0);
    prev_grant = bus.grant;
  endtask

  // Requester behaviour for directed tests: drop req on seeing rvalid.
  task automatic step_drop();
    step();
    for (int i = 0; i < int'(N); i++) begin
      if (bus.rvalid[i]) bus.req[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    bus.req      = '0;
    bus.req_addr = '0;
    reset_n      = 1'b0;
    #1;
    check_val("rst_grant", bus.grant, 0);
    check_val("rst_rvalid", bus.rvalid, 0);
    check_val("rst_rdata", bus.rdata, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_s_address", bus.s_address, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.s_readdata = '0;
    for (int j = 0; j < 4; j++) regs[j] = $urandom;
    model_reset();

    // Single request from requester 2.
    apply_reset();
    regs[0] = 32'h0000_00A5;
    bus.req = 4'b0100;
    step_drop();
    check_val("t1_grant", bus.grant, 4'b0100);
    check_val("t1_s_address", bus.s_address, 0);
    step_drop();
    step_drop();
    check_val("t1_rvalid", bus.rvalid, 4'b0100);
    check_val("t1_rdata", bus.rdata, 32'h0000_00A5);
    repeat (3) step_drop();

    // All four continuously requesting: 0,1,2,3,0,1 at 4-cycle spacing.
    apply_reset();
    bus.req = 4'b1111;
    order.delete();
    when.delete();
    repeat (24) begin
      step();
      for (int i = 0; i < int'(N); i++) begin
        if (bus.rvalid[i]) begin
          order.push_back(i);
          when.push_back(cyc);
        end
      end
    end
    check_val("t2_count", order.size(), 6);
    for (int j = 0; j < order.size() && j < 6; j++) begin
      check_val("t2_order", order[j], j % 4);
      if (j > 0) check_val("t2_spacing", when[j] - when[j-1], 4);
    end

    // last_grant = 1, then req = 1010: 3 before 1, 0 and 2 never served.
    apply_reset();
    bus.req = 4'b0010;
    repeat (5) step_drop();
    bus.req = 4'b1010;
    order.delete();
    side_hits = 0;
    repeat (12) begin
      step_drop();
      for (int i = 0; i < int'(N); i++) begin
        if (bus.rvalid[i]) order.push_back(i);
      end
      if (bus.rvalid[0] || bus.rvalid[2]) side_hits++;
    end
    check_val("t3_count", order.size(), 2);
    if (order.size() == 2) begin
      check_val("t3_first", order[0], 3);
      check_val("t3_second", order[1], 1);
    end
    check_val("t3_side", side_hits, 0);

    // Requester 2 changes address and drops req while the read is in flight.
    apply_reset();
    regs[0] = 32'h0000_0011;
    regs[3] = 32'h0000_0033;
    bus.req = 4'b0100;
    step();
    bus.req_addr[5:4] = 2'd3;
    bus.req[2]        = 1'b0;
    step();
    check_val("t4_s_address", bus.s_address, 0);
    step();
    check_val("t4_rvalid", bus.rvalid, 4'b0100);
    check_val("t4_rdata", bus.rdata, 32'h0000_0011);
    bus.req_addr = '0;
    repeat (2) step();

    // Reset during CAPTURE aborts the read; held request is served afterwards.
    bus.req = 4'b0001;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_val("t5_rdata", bus.rdata, 0);
    check_val("t5_grant", bus.grant, 0);
    check_val("t5_rvalid", bus.rvalid, 0);
    check_val("t5_busy", bus.busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_val("t5_rvalid_hold", bus.rvalid, 0);
    reset_n = 1'b1;
    step();
    check_val("t5_regrant", bus.grant, 4'b0001);
    step();
    step_drop();
    check_val("t5_rvalid_after", bus.rvalid, 4'b0001);
    check_val("t5_rdata_after", bus.rdata, 32'h0000_0011);

    // Random traffic with a mid-run reset.
    apply_reset();
    for (int j = 0; j < 4; j++) regs[j] = $urandom;
    hold = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        apply_reset();
        hold = '0;
      end
      step();
      for (int i = 0; i < int'(N); i++) begin
        if (bus.rvalid[i]) begin
          hold[i]    = 1'b0;
          bus.req[i] = 1'b0;
        end else if (!hold[i]) begin
          if ($urandom_range(3) == 0) begin
            hold[i]                = 1'b1;
            bus.req[i]             = 1'b1;
            bus.req_addr[2*i +: 2] = 2'($urandom_range(3));
          end
        end else if (bus.grant[i]) begin
          if ($urandom_range(7) == 0) bus.req[i] = 1'b0;
          if ($urandom_range(3) == 0) bus.req_addr[2*i +: 2] = 2'($urandom_range(3));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/monitor_pio_arb.md
MONITOR_PIO_ARB -- requirements
Module: monitor_pio_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one PIO read slave; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: PIO readdata width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  per-requester read request; requester holds it high until its rvalid pulse.
REQ-006 req_addr  input  2*N_REQ  per-requester PIO register address; requester i uses bits [2i+1:2i].
REQ-007 grant  output  N_REQ  one-hot registered grant, or all-zero when idle.
REQ-008 rvalid  output  N_REQ  one-cycle pulse to the granted requester when rdata is valid.
REQ-009 rdata  output  DATA_W  registered read data, shared by all requesters.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 s_address  output  2  address driven to the PIO slave.
REQ-012 s_readdata  input  DATA_W  PIO slave readdata, registered in the slave; valid one clock after s_address.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, CAPTURE.
REQ-014 In IDLE with req == 0, the FSM SHALL stay in IDLE with grant = 0 and s_address = 0.
REQ-015 In IDLE with any req bit high, the FSM SHALL select one winner by round-robin and enter WAIT on the next edge.
- Search starts at index (last_grant+1) mod N_REQ and ascends with wrap-around.
- grant SHALL become one-hot at the winner.
- s_address SHALL be loaded with the winner's req_addr.
REQ-016 In WAIT, grant and s_address SHALL hold, and the FSM SHALL enter CAPTURE on the next edge.
REQ-017 In CAPTURE, on the exiting edge, the block SHALL:
- register s_readdata into rdata;
- pulse rvalid at the granted index for one cycle;
- set last_grant to the winner;
- clear grant to 0 and s_address to 0;
- return to IDLE.
REQ-018 Latency SHALL be fixed: req sampled high at edge k gives grant at k+1 and the rvalid pulse with rdata valid in the cycle after edge k+3.
REQ-019 rdata SHALL hold its value until the next CAPTURE; rvalid SHALL be 0 in every other cycle.
REQ-020 req and req_addr changes during WAIT or CAPTURE SHALL NOT affect the transaction in flight.
- s_address SHALL keep the address latched in IDLE.
- A requester that drops req mid-transaction still receives its rvalid pulse.
REQ-021 After CAPTURE the FSM SHALL pass through IDLE for at least one cycle, so one transaction completes every 4 cycles under continuous load.
REQ-022 Fairness: with all requests continuously high, each requester SHALL be granted exactly once in every N_REQ consecutive transactions.
REQ-023 At most one grant bit and at most one rvalid bit SHALL be high in any cycle.
REQ-024 A requester whose req is low in IDLE SHALL be skipped with no penalty; its position in the rotation is unchanged.

Reset
REQ-025 While reset_n is low, the block SHALL force the following immediately, independent of clk:
- state = IDLE, grant = 0, rvalid = 0;
- rdata = 0, s_address = 0, busy = 0;
- last_grant = N_REQ-1, so requester 0 has first priority.
REQ-026 Reset asserted mid-transaction SHALL abort it with no rvalid pulse; after release, a pending req is re-arbitrated from IDLE.
REQ-027 Reset release SHALL be synchronous to clk; the first arbitration occurs on the first edge with reset_n high.

Verification
REQ-028 Single request (N_REQ=4): req=0100, req_addr[5:4]=0, s_readdata=0x000000A5 -> grant=0100 at k+1, s_address=0, rvalid=0100 with rdata=0x000000A5 after k+3.
REQ-029 All four requesting continuously from reset -> grant order 0,1,2,3,0,1; one rvalid pulse every 4 cycles.
REQ-030 req=1010 with last_grant=1 -> requester 3 is granted first, then requester 1; requesters 0 and 2 never receive rvalid.
REQ-031 Requester 2 changes req_addr from 0 to 3 and drops req during WAIT -> s_address stays 0 and rvalid[2] still pulses with the address-0 data.
REQ-032 reset_n pulsed low during CAPTURE -> no rvalid; rdata=0 and grant=0 immediately; the pending request is re-served after release.
REQ-033 Assertions over random traffic: grant is one-hot or zero; rvalid is a subset of the previous-cycle grant; busy equals (grant != 0) or CAPTURE.
